sram_axi_bridge: RTL

Converts the CPU core's two SRAM-like ports (instruction and data: req/addr_ok/data_ok) into a single AXI3 master for the SoC interconnect. Sits directly downstream of the CPU top level: the core's `inst_sram_*` and `data_sram_*` buses terminate here, and the AXI buses leave toward memory. It handles read arbitration, write sequencing and response routing by ID, with at most one read and one write in flight.

---
 rtl/sram_axi_bridge_pkg.sv | 12 +
 rtl/sram_axi_bridge.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-like to AXI3 bridge.
package sram_axi_bridge_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction/data SRAM-like ports onto one AXI3 master,
// with at most one read and one write in flight.
//
// state  | meaning
// R_IDLE | no read in flight, may accept data or instruction read
// R_ADDR | arvalid high, waiting for arready
// R_DATA | rready high, waiting for rvalid
// W_IDLE | no write in flight, may accept data write
// W_SEND | aw/w channels pending, each drops on its own handshake
// W_RESP | bready high, waiting for bvalid
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  r_state_t r_state;
  w_state_t w_state;

  logic r_data_busy, data_rd_acc, inst_rd_acc, data_wr_acc;

  logic unused_ok;
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       rresp, rlast, bid, bresp};

  // The data port allows one outstanding transaction, read or write.
  assign r_data_busy = (r_state != R_IDLE) && (arid == ID_DATA);
  assign data_rd_acc = (r_state == R_IDLE) && data_sram_req && !data_sram_wr &&
                       (w_state == W_IDLE);
  assign inst_rd_acc = (r_state == R_IDLE) && inst_sram_req && !data_rd_acc;
  assign data_wr_acc = (w_state == W_IDLE) && data_sram_req && data_sram_wr &&
                       !r_data_busy;

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_sram_data_ok = rready && rvalid && (rid == ID_INST);
  assign data_sram_data_ok = (rready && rvalid && (rid == ID_DATA)) ||
                             (bready && bvalid);
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awlen   = LEN_SINGLE;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awid    = ID_DATA;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      arid    <= 4'd0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (data_rd_acc) begin
            arid    <= ID_DATA;
            araddr  <= data_sram_addr;
            arsize  <= {1'b0, data_sram_size};
            arvalid <= 1'b1;
            r_state <= R_ADDR;
          end else if (inst_rd_acc) begin
            arid    <= ID_INST;
            araddr  <= inst_sram_addr;
            arsize  <= {1'b0, inst_sram_size};
            arvalid <= 1'b1;
            r_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid) begin
            rready  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (data_wr_acc) begin
            awaddr  <= data_sram_addr;
            awsize  <= {1'b0, data_sram_size};
            wdata   <= data_sram_wdata;
            wstrb   <= data_sram_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            w_state <= W_SEND;
          end
        end
        W_SEND: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
